// File: rtl/definesPkg.sv
// Shared AHB-Lite bus widths and transfer encodings.
// Used by the master arbiter and its round-robin picker.
package definesPkg;

  localparam int ADDRESS_WIDTH = 32;
  localparam int DATA_WIDTH    = 32;
  localparam int HSIZE_WIDTH   = 3;
  localparam int BURST_SIZE    = 3;
  localparam int TRANSFER_TYPE = 2;
  localparam int MAX_MASTERS   = 4;

  typedef enum logic [TRANSFER_TYPE-1:0] {
    IDLE   = 2'b00,
    BUSY   = 2'b01,
    NONSEQ = 2'b10,
    SEQ    = 2'b11
  } htrans_e;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin pick: first request after cur,
// wrapping modulo N, with cur itself scanned last.
module rr_picker #(
  parameter int N = 2,
  localparam int MW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [MW-1:0] cur,
  output logic [MW-1:0] nxt,
  output logic          found
);

  always_comb begin
    logic [MW-1:0] idx;
    nxt   = cur;
    found = 1'b0;
    idx   = '0;
    for (int k = 1; k <= N; k++) begin
      idx = MW'((int'(cur) + k) % N);
      if (!found && req[idx]) begin
        nxt   = idx;
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ahb_lite_master_arbiter.sv
// Round-robin sharing of one AHB-Lite master port between
// NUM_MASTERS masters, with split address/data ownership.
module ahb_lite_master_arbiter
  import definesPkg::*;
#(
  parameter int NUM_MASTERS = 2,
  localparam int MW = $clog2(NUM_MASTERS)
) (
  input  logic HCLK,
  input  logic HRESETn,

  input  logic [NUM_MASTERS-1:0][ADDRESS_WIDTH-1:0] m_HADDR,
  input  logic [NUM_MASTERS-1:0][TRANSFER_TYPE-1:0] m_HTRANS,
  input  logic [NUM_MASTERS-1:0]                    m_HWRITE,
  input  logic [NUM_MASTERS-1:0][HSIZE_WIDTH-1:0]   m_HSIZE,
  input  logic [NUM_MASTERS-1:0][BURST_SIZE-1:0]    m_HBURST,
  input  logic [NUM_MASTERS-1:0][DATA_WIDTH-1:0]    m_HWDATA,
  output logic [NUM_MASTERS-1:0]                    m_HREADY,
  output logic [NUM_MASTERS-1:0]                    m_HRESP,
  output logic [DATA_WIDTH-1:0]                     m_HRDATA,

  output logic [ADDRESS_WIDTH-1:0] HADDR,
  output logic [TRANSFER_TYPE-1:0] HTRANS,
  output logic                     HWRITE,
  output logic [HSIZE_WIDTH-1:0]   HSIZE,
  output logic [BURST_SIZE-1:0]    HBURST,
  output logic [DATA_WIDTH-1:0]    HWDATA,
  input  logic                     HREADY,
  input  logic                     HRESP,
  input  logic [DATA_WIDTH-1:0]    HRDATA,
  output logic [MW-1:0]            HMASTER
);

  logic [MW-1:0] addr_own_q, addr_own_d;
  logic [MW-1:0] data_own_q, data_own_d;
  logic          data_vld_q, data_vld_d;

  logic [NUM_MASTERS-1:0] req;
  logic [MW-1:0]          pick;
  logic                   pick_found;
  logic                   handover;

  always_comb begin
    req = '0;
    for (int j = 0; j < NUM_MASTERS; j++) begin
      req[j] = (m_HTRANS[j] == NONSEQ);
    end
  end

  rr_picker #(
    .N(NUM_MASTERS)
  ) u_picker (
    .req   (req),
    .cur   (addr_own_q),
    .nxt   (pick),
    .found (pick_found)
  );

  // Bursts (SEQ/BUSY) and back-to-back NONSEQs keep the bus.
  assign handover = HREADY &&
                    (m_HTRANS[addr_own_q] == IDLE);

  assign HADDR   = m_HADDR[addr_own_q];
  assign HWRITE  = m_HWRITE[addr_own_q];
  assign HSIZE   = m_HSIZE[addr_own_q];
  assign HBURST  = m_HBURST[addr_own_q];
  assign HTRANS  = HRESETn ? m_HTRANS[addr_own_q] : IDLE;
  assign HWDATA  = m_HWDATA[data_own_q];
  assign HMASTER = addr_own_q;
  assign m_HRDATA = HRDATA;

  always_comb begin
    m_HREADY = '0;
    m_HRESP  = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (!HRESETn) begin
        m_HREADY[i] = 1'b1;
      end else if (MW'(i) == addr_own_q) begin
        m_HREADY[i] = HREADY;
      end
      if (data_vld_q && (MW'(i) == data_own_q)) begin
        m_HRESP[i] = HRESP;
      end
    end
  end

  always_comb begin
    addr_own_d = addr_own_q;
    data_own_d = data_own_q;
    data_vld_d = data_vld_q;
    if (HREADY) begin
      data_own_d = addr_own_q;
      data_vld_d = HTRANS[1];
      if (handover && pick_found) begin
        addr_own_d = pick;
      end
    end
  end

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      addr_own_q <= '0;
      data_own_q <= '0;
      data_vld_q <= 1'b0;
    end else begin
      addr_own_q <= addr_own_d;
      data_own_q <= data_own_d;
      data_vld_q <= data_vld_d;
    end
  end

endmodule

// File: doc/ahb_lite_master_arbiter.md
Name: ahb_lite_master_arbiter

Overview:
- Shares the single AHB-Lite master port of the bus (the HADDR/HTRANS/HWDATA/HRDATA/HREADY/HRESP set defined in definesPkg) between NUM_MASTERS requesting masters.
- Round-robin arbitration at transfer boundaries, with separate address-phase and data-phase ownership so pipelining is preserved.
- Non-granted masters are stalled via their private HREADY.
- Sits between the UVM master agents (or RTL masters) and the AHB-Lite slave/DUT.

Parameters:
- NUM_MASTERS, 2: number of requesting masters; legal 2..4.
- MW, $clog2(NUM_MASTERS): master index width (localparam).
- Bus widths come from definesPkg (ADDRESS_WIDTH, DATA_WIDTH, HSIZE_WIDTH, BURST_SIZE, TRANSFER_TYPE); they are not local parameters.

Ports:
- HCLK  in  1  bus clock.
- HRESETn  in  1  reset; synchronous, active-low.
- m_HADDR  in  NUM_MASTERS x ADDRESS_WIDTH  per-master address.
- m_HTRANS  in  NUM_MASTERS x TRANSFER_TYPE  per-master transfer type.
- m_HWRITE  in  NUM_MASTERS x 1  per-master direction.
- m_HSIZE  in  NUM_MASTERS x HSIZE_WIDTH  per-master size.
- m_HBURST  in  NUM_MASTERS x BURST_SIZE  per-master burst.
- m_HWDATA  in  NUM_MASTERS x DATA_WIDTH  per-master write data.
- m_HREADY  out  NUM_MASTERS  per-master ready.
- m_HRESP  out  NUM_MASTERS  per-master response.
- m_HRDATA  out  DATA_WIDTH  read data, broadcast to all masters.
- HADDR, HTRANS, HWRITE, HSIZE, HBURST, HWDATA  out  package widths  muxed bus to slave.
- HREADY  in  1  slave ready.
- HRESP  in  1  slave response.
- HRDATA  in  DATA_WIDTH  slave read data.
- HMASTER  out  MW  current address-phase owner.

Behaviour:
- State registers:
  - addr_own [MW]: address-phase owner.
  - data_own [MW]: data-phase owner.
  - data_vld: a NONSEQ/SEQ data phase is in flight.
- Reset, sampled on HCLK while HRESETn=0:
  - addr_own=0, data_own=0, data_vld=0.
  - While HRESETn=0, HTRANS is forced to IDLE (2'b00) and m_HREADY=all 1s.
- Address mux: HADDR/HTRANS/HWRITE/HSIZE/HBURST = m_* of addr_own. This path is combinational, with zero-cycle latency.
- Data mux: HWDATA = m_HWDATA[data_own]. m_HRDATA = HRDATA to all masters.
- m_HREADY[i]:
  - Equals HREADY if i==addr_own.
  - Otherwise 0, so waiting masters hold their NONSEQ per the AHB-Lite rule.
- m_HRESP[i]: equals HRESP if data_vld and i==data_own; otherwise 0 (OKAY).
- Pipeline advance: on HCLK edge with HREADY=1:
  - data_own <= addr_own.
  - data_vld <= HTRANS[1] (NONSEQ or SEQ).
  - With HREADY=0, all state holds.
- Handover condition: HREADY=1 and m_HTRANS[addr_own]==IDLE.
  - BUSY, SEQ and NONSEQ never hand over, so bursts and locked sequences stay atomic.
- Request: req[j] = (m_HTRANS[j]==NONSEQ).
- Arbitration: at a handover edge, addr_own <= first j with req[j], scanning addr_own+1, addr_own+2, … modulo NUM_MASTERS.
  - The scan includes addr_own last.
  - If no requester, addr_own is unchanged (park on last owner).
- Handover latency: the outgoing owner's IDLE is on the bus in cycle t; the new owner's NONSEQ is on the bus in cycle t+1. The minimum gap between different masters is 1 IDLE cycle.
- Data-phase continuity: the previous owner's data phase (HWDATA, HRESP, HREADY wait states) completes through data_own even after addr_own changes.
  - The old owner sees m_HREADY=0 after handover. Because its last address was IDLE, it has no pending data phase by then. This is legal.
- ERROR response:
  - The two-cycle HRESP=1 is routed to data_own only.
  - The owner driving IDLE in the second ERROR cycle triggers normal handover.
- Reset mid-transfer: state returns to reset values at the next edge; in-flight data phase is discarded and HTRANS is forced IDLE.
- Slave ready: HREADY stuck low holds everything; no timeout.

Decomposition:
- Add to definesPkg:
  - htrans_e enum: IDLE=2'b00, BUSY=2'b01, NONSEQ=2'b10, SEQ=2'b11.
  - MAX_MASTERS=4 constant.
- Sub-module rr_picker (NUM_MASTERS-bit request, current index → next index).
  - Combinational round-robin priority rotate.
  - Instantiated once.

Test Plan:
- Single master: m0 NONSEQ write 0x100, data 0xDEADBEEF, m1 IDLE.
  - HADDR=0x100 same cycle; HWDATA=0xDEADBEEF next cycle; HMASTER=0 throughout.
  - m_HREADY[1]=0.
- Contention after reset: m0 and m1 both NONSEQ at cycle 1.
  - m0 owns first; m0 drives IDLE at cycle 3.
  - HMASTER=1 at cycle 4 and m1's NONSEQ appears at cycle 4.
- Burst atomicity: m0 INCR4 from 0x200 (NONSEQ, SEQ, SEQ, SEQ) while m1 requests from beat 1.
  - All 4 beats 0x200..0x20C are issued contiguously.
  - m1 is granted only after m0's IDLE.
- Slave wait states: HREADY=0 for 2 cycles during m0's data phase coinciding with handover.
  - data_own stays 0 and HWDATA holds.
  - m1's NONSEQ is not advanced until HREADY=1.
- ERROR routing: slave returns HRESP=1 for 2 cycles on m1's read to 0x300.
  - m_HRESP[1]=1 for 2 cycles; m_HRESP[0]=0.
- Reset mid-burst: HRESETn=0 during m1's SEQ beat 2.
  - Next edge: HMASTER=0, HTRANS=IDLE, data_vld=0.
  - After release, m0 is granted first.
